// File: rtl/snake_step_scheduler.sv
// rtl/snake_step_scheduler.sv - snake step pacing, direction commit and play countdown (option macro: SNAKE_SPEEDUP_EN)
module snake_step_scheduler #(
  parameter int BASE_PERIOD = 25_000_000,
  parameter int SPEED_STEP  = 2_000_000,
  parameter int MIN_PERIOD  = 5_000_000,
  parameter int ONE_SEC     = 100_000_000,
  parameter int TIME_LIMIT  = 60
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic [1:0] Play_State,
  input  logic [3:0] Score,
  output logic       Step,
  output logic [1:0] Direction,
  output logic [7:0] Seconds_Left,
  output logic       time_is_up
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } play_state_e;

  localparam logic [1:0]  DIR_UP          = 2'b00;
  localparam logic [1:0]  DIR_DOWN        = 2'b01;
  localparam logic [1:0]  DIR_LEFT        = 2'b10;
  localparam logic [1:0]  DIR_RIGHT       = 2'b11;
  localparam logic [31:0] ONE_SEC_LAST    = 32'(ONE_SEC - 1);
  localparam logic [7:0]  TIME_LIMIT_SECS = 8'(TIME_LIMIT);

  play_state_e play_state;
  assign play_state = play_state_e'(Play_State);

  // Button vectors are packed {U, D, L, R}.
  logic [3:0]         btn_q, btn_d;
  logic [3:0]         edge_q, edge_d;
  logic [1:0]         pending_q, pending_d;
  logic [1:0]         direction_q, direction_d;
  logic               step_q, step_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        presc_q, presc_d;
  logic [7:0]         secs_q, secs_d;
  logic               time_up_q, time_up_d;
  logic signed [31:0] period;
  logic [31:0]        period_last;
  logic               cand_valid;
  logic [1:0]         cand_dir;

`ifdef SNAKE_SPEEDUP_EN
  logic signed [31:0] raw_period;

  // Step period shrinks with score, floored at MIN_PERIOD.
  always_comb begin
    raw_period = BASE_PERIOD - int'(Score) * SPEED_STEP;
    period     = (raw_period < MIN_PERIOD) ? MIN_PERIOD : raw_period;
  end
`else
  localparam int unused_speed_params = SPEED_STEP + MIN_PERIOD;
  logic unused_score;
  assign unused_score = ^Score;
  assign period       = BASE_PERIOD;
`endif

  assign period_last = 32'(period - 1);

  // Edge-detect the buttons, then pick one candidate from the registered edges (U > D > L > R).
  always_comb begin
    btn_d      = {BTNU, BTND, BTNL, BTNR};
    edge_d     = btn_d & ~btn_q;
    cand_valid = 1'b1;
    cand_dir   = DIR_RIGHT;
    if (edge_q[3])      cand_dir   = DIR_UP;
    else if (edge_q[2]) cand_dir   = DIR_DOWN;
    else if (edge_q[1]) cand_dir   = DIR_LEFT;
    else if (edge_q[0]) cand_dir   = DIR_RIGHT;
    else                cand_valid = 1'b0;
  end

  // Step counter runs only in PLAY; reaching the period emits a one-cycle Step.
  always_comb begin
    count_d = '0;
    step_d  = 1'b0;
    if (play_state == ST_PLAY) begin
      if (count_q >= period_last) step_d  = 1'b1;
      else                        count_d = count_q + 32'd1;
    end
  end

  // IDLE loads heading directly; PLAY buffers non-reversing presses and commits on Step.
  always_comb begin
    pending_d   = pending_q;
    direction_d = direction_q;
    case (play_state)
      ST_IDLE: begin
        if (cand_valid) begin
          pending_d   = cand_dir;
          direction_d = cand_dir;
        end
      end
      ST_PLAY: begin
        // U/D and L/R differ only in the low bit, so XOR gives the opposite heading.
        if (cand_valid && (cand_dir != (direction_q ^ 2'b01))) pending_d = cand_dir;
        if (step_d) direction_d = pending_q;
      end
      default: begin
      end
    endcase
  end

  // Play-time countdown: reloaded in IDLE, runs in PLAY, frozen in WIN/LOSE, saturates at 0.
  always_comb begin
    presc_d   = presc_q;
    secs_d    = secs_q;
    time_up_d = time_up_q;
    case (play_state)
      ST_IDLE: begin
        presc_d   = '0;
        secs_d    = TIME_LIMIT_SECS;
        time_up_d = 1'b0;
      end
      ST_PLAY: begin
        if (secs_q != 8'd0) begin
          if (presc_q >= ONE_SEC_LAST) begin
            presc_d = '0;
            secs_d  = secs_q - 8'd1;
            if (secs_q == 8'd1) time_up_d = 1'b1;
          end else begin
            presc_d = presc_q + 32'd1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_q       <= '0;
      edge_q      <= '0;
      pending_q   <= DIR_RIGHT;
      direction_q <= DIR_RIGHT;
      step_q      <= 1'b0;
      count_q     <= '0;
      presc_q     <= '0;
      secs_q      <= TIME_LIMIT_SECS;
      time_up_q   <= 1'b0;
    end else begin
      btn_q       <= btn_d;
      edge_q      <= edge_d;
      pending_q   <= pending_d;
      direction_q <= direction_d;
      step_q      <= step_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      secs_q      <= secs_d;
      time_up_q   <= time_up_d;
    end
  end

  assign Step         = step_q;
  assign Direction    = direction_q;
  assign Seconds_Left = secs_q;
  assign time_is_up   = time_up_q;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// tb/tb_snake_step_scheduler.sv - randomized self-checking bench for snake_step_scheduler
module tb_snake_step_scheduler;

  localparam int BASE = 10;
  localparam int SPD  = 2;
  localparam int MINP = 4;
  localparam int SEC  = 5;
  localparam int TL   = 3;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_WIN  = 2'b10;
  localparam logic [1:0] S_LOSE = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
  logic [1:0] play_state = 2'b00;
  logic [3:0] score = 4'd0;
  logic       step;
  logic [1:0] dir;
  logic [7:0] secs;
  logic       tiu;

  int checks = 0;
  int errors = 0;
  logic [1:0] m_dir;

  always #5 clk = ~clk;

  snake_step_scheduler #(
    .BASE_PERIOD(BASE), .SPEED_STEP(SPD), .MIN_PERIOD(MINP), .ONE_SEC(SEC), .TIME_LIMIT(TL)
  ) dut (
    .CLK(clk), .RESET_N(rst_n),
    .BTNU(btnu), .BTND(btnd), .BTNL(btnl), .BTNR(btnr),
    .Play_State(play_state), .Score(score),
    .Step(step), .Direction(dir), .Seconds_Left(secs), .time_is_up(tiu)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] m);
    {btnu, btnd, btnl, btnr} = m;
  endtask

`ifdef SNAKE_SPEEDUP_EN
  function automatic int model_period(input int s);
    int p;
    p = BASE - s * SPD;
    if (p < MINP) p = MINP;
    return p;
  endfunction
`else
  function automatic int model_period(input int s);
    return (s >= 0) ? BASE : BASE;
  endfunction
`endif

  // Seconds remaining after a given number of PLAY cycles.
  function automatic logic [7:0] model_secs(input int play_cycles);
    int used;
    used = play_cycles / SEC;
    return (used >= TL) ? 8'd0 : 8'(TL - used);
  endfunction

  // Same-cycle priority U > D > L > R over a {U,D,L,R} mask.
  function automatic logic [1:0] pick(input logic [3:0] m);
    if (m[3]) return 2'd0;
    if (m[2]) return 2'd1;
    if (m[1]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'd0 && b == 2'd1) || (a == 2'd1 && b == 2'd0) ||
           (a == 2'd2 && b == 2'd3) || (a == 2'd3 && b == 2'd2);
  endfunction

  // Button mask that requests the heading opposite to d.
  function automatic logic [3:0] rev_mask(input logic [1:0] d);
    case (d)
      2'd0:    return 4'b0100;
      2'd1:    return 4'b1000;
      2'd2:    return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic go_idle(input int n);
    play_state = S_IDLE;
    set_btn(4'b0000);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    checks++; if (step !== 1'b0)  begin errors++; $display("FAIL reset_step: got %0b expected 0", step); end
    checks++; if (dir !== 2'd3)   begin errors++; $display("FAIL reset_dir: got %0d expected 3", dir); end
    checks++; if (secs !== 8'(TL)) begin errors++; $display("FAIL reset_secs: got %0d expected %0d", secs, TL); end
    checks++; if (tiu !== 1'b0)   begin errors++; $display("FAIL reset_tiu: got %0b expected 0", tiu); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (dir !== 2'd3)   begin errors++; $display("FAIL reset_idle_dir: got %0d expected 3", dir); end
    checks++; if (secs !== 8'(TL)) begin errors++; $display("FAIL reset_idle_secs: got %0d expected %0d", secs, TL); end
    m_dir = 2'd3;
  endtask

  task automatic test_step_period();
    logic [3:0] scores [6];
    scores[0] = 4'd0; scores[1] = 4'd2; scores[2] = 4'd5; scores[3] = 4'd7;
    scores[4] = 4'($urandom_range(0, 15)); scores[5] = 4'($urandom_range(0, 15));
    for (int s = 0; s < 6; s++) begin
      int p;
      logic exp_step;
      go_idle(2);
      score = scores[s];
      p = model_period(int'(scores[s]));
      play_state = S_PLAY;
      for (int k = 1; k <= 24; k++) begin
        tick();
        exp_step = (k % p == 0);
        checks++;
        if (step !== exp_step) begin errors++; $display("FAIL step_period score=%0d k=%0d: got %0b expected %0b", scores[s], k, step, exp_step); end
        checks++;
        if (secs !== model_secs(k)) begin errors++; $display("FAIL step_secs score=%0d k=%0d: got %0d expected %0d", scores[s], k, secs, model_secs(k)); end
        checks++;
        if (tiu !== (k >= SEC * TL)) begin errors++; $display("FAIL step_tiu k=%0d: got %0b expected %0b", k, tiu, (k >= SEC * TL)); end
      end
    end
  endtask

  task automatic test_score_jump();
    int jumps [3];
    jumps[0] = 7; jumps[1] = int'($urandom_range(4, 9)); jumps[2] = int'($urandom_range(4, 9));
    for (int t = 0; t < 3; t++) begin
      int j;
      int p4;
      logic exp_step;
      j = jumps[t];
      p4 = model_period(4);
      go_idle(2);
      score = 4'd0;
      play_state = S_PLAY;
      for (int k = 1; k <= 20; k++) begin
        tick();
`ifdef SNAKE_SPEEDUP_EN
        exp_step = (k == j + 1) || (k > j + 1 && ((k - j - 1) % p4) == 0);
`else
        exp_step = (k % p4 == 0);
`endif
        checks++;
        if (step !== exp_step) begin errors++; $display("FAIL score_jump j=%0d k=%0d: got %0b expected %0b", j, k, step, exp_step); end
        if (k == j) score = 4'd4;
      end
    end
  endtask

  task automatic test_play_direction();
    logic [3:0] mask_at [23];
    logic [1:0] pend, exp1, exp2, exp_dir;
    for (int k = 0; k < 23; k++) mask_at[k] = 4'b0000;
    mask_at[2]  = 4'b0010;
    mask_at[4]  = 4'b1000;
    mask_at[11] = 4'($urandom_range(1, 15));
    mask_at[13] = 4'($urandom_range(1, 15));
    mask_at[15] = 4'($urandom_range(1, 15));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    go_idle(2);
    score = 4'd0;
    pend = 2'd3;
    for (int k = 1; k < 10; k++)
      if (mask_at[k] != 4'b0000 && !is_reverse(pick(mask_at[k]), 2'd3)) pend = pick(mask_at[k]);
    exp1 = pend;
    for (int k = 10; k < 20; k++)
      if (mask_at[k] != 4'b0000 && !is_reverse(pick(mask_at[k]), exp1)) pend = pick(mask_at[k]);
    exp2 = pend;
    play_state = S_PLAY;
    for (int k = 1; k <= 22; k++) begin
      tick();
      exp_dir = (k < 10) ? 2'd3 : (k < 20) ? exp1 : exp2;
      checks++;
      if (dir !== exp_dir) begin errors++; $display("FAIL play_dir k=%0d: got %0d expected %0d", k, dir, exp_dir); end
      if (k == 10 || k == 20) begin
        checks++;
        if (step !== 1'b1) begin errors++; $display("FAIL play_dir_step k=%0d: got %0b expected 1", k, step); end
      end
      set_btn(mask_at[k]);
    end
    set_btn(4'b0000);
    m_dir = exp2;
  endtask

  task automatic test_idle_direction();
    go_idle(2);
    for (int it = 0; it < 5; it++) begin
      logic [3:0] m;
      m = (it == 0) ? rev_mask(m_dir) : 4'($urandom_range(1, 15));
      set_btn(m);
      tick();
      checks++;
      if (dir !== m_dir) begin errors++; $display("FAIL idle_dir_early it=%0d: got %0d expected %0d", it, dir, m_dir); end
      set_btn(4'b0000);
      tick();
      m_dir = pick(m);
      checks++;
      if (dir !== m_dir) begin errors++; $display("FAIL idle_dir it=%0d: got %0d expected %0d", it, dir, m_dir); end
      tick();
    end
  endtask

  task automatic test_countdown();
    int played;
    go_idle(2);
    score = 4'd0;
    play_state = S_PLAY;
    for (int k = 1; k <= 18; k++) begin
      tick();
      checks++;
      if (secs !== model_secs(k)) begin errors++; $display("FAIL cd_secs k=%0d: got %0d expected %0d", k, secs, model_secs(k)); end
      checks++;
      if (tiu !== (k >= 15)) begin errors++; $display("FAIL cd_tiu k=%0d: got %0b expected %0b", k, tiu, (k >= 15)); end
      checks++;
      if (step !== (k % 10 == 0)) begin errors++; $display("FAIL cd_step k=%0d: got %0b expected %0b", k, step, (k % 10 == 0)); end
    end
    play_state = S_LOSE;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (secs !== 8'd0 || tiu !== 1'b1 || step !== 1'b0) begin
        errors++; $display("FAIL lose_hold k=%0d: got secs=%0d tiu=%0b step=%0b expected 0 1 0", k, secs, tiu, step);
      end
    end
    play_state = S_IDLE;
    tick();
    checks++;
    if (secs !== 8'(TL) || tiu !== 1'b0) begin errors++; $display("FAIL idle_reload: got secs=%0d tiu=%0b expected %0d 0", secs, tiu, TL); end
    tick();
    play_state = S_PLAY;
    for (int k = 1; k <= 9; k++) tick();
    play_state = S_WIN;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (step !== 1'b0 || secs !== model_secs(9) || tiu !== 1'b0) begin
        errors++; $display("FAIL win_hold k=%0d: got step=%0b secs=%0d tiu=%0b expected 0 %0d 0", k, step, secs, tiu, model_secs(9));
      end
    end
    play_state = S_PLAY;
    played = 9;
    for (int k = 1; k <= 5; k++) begin
      tick();
      played++;
      checks++;
      if (secs !== model_secs(played)) begin errors++; $display("FAIL resume_secs k=%0d: got %0d expected %0d", k, secs, model_secs(played)); end
      checks++;
      if (step !== 1'b0) begin errors++; $display("FAIL resume_step k=%0d: got %0b expected 0", k, step); end
    end
  endtask

  task automatic test_reset_midplay();
    go_idle(2);
    score = 4'd0;
    play_state = S_PLAY;
    for (int k = 1; k <= 13; k++) tick();
    rst_n = 1'b0;
    #2;
    checks++; if (step !== 1'b0)   begin errors++; $display("FAIL midrst_step: got %0b expected 0", step); end
    checks++; if (dir !== 2'd3)    begin errors++; $display("FAIL midrst_dir: got %0d expected 3", dir); end
    checks++; if (secs !== 8'(TL)) begin errors++; $display("FAIL midrst_secs: got %0d expected %0d", secs, TL); end
    checks++; if (tiu !== 1'b0)    begin errors++; $display("FAIL midrst_tiu: got %0b expected 0", tiu); end
    tick();
    rst_n = 1'b1;
    m_dir = 2'd3;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (step !== (k == 10)) begin errors++; $display("FAIL post_rst_step k=%0d: got %0b expected %0b", k, step, (k == 10)); end
      checks++;
      if (secs !== model_secs(k)) begin errors++; $display("FAIL post_rst_secs k=%0d: got %0d expected %0d", k, secs, model_secs(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_step_period();
    test_score_jump();
    test_play_direction();
    test_idle_direction();
    test_countdown();
    test_reset_midplay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
